// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: write-back select, register-file write port and forwarding bus.
// Define RETIRE_COUNT_EN to build the 64-bit retired-instruction counter; otherwise instret is tied to 0.
module mem_wb_stage #(
  parameter int OPERAND_WIDTH  = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_valid,
  input  logic [OPERAND_WIDTH-1:0]  mem_alu_result,
  input  logic [31:0]               mem_data,
  input  logic [OPERAND_WIDTH-1:0]  mem_pc_plus4,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_reg_write,
  input  logic [1:0]                mem_wb_sel,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [OPERAND_WIDTH-1:0]  rf_wdata,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [OPERAND_WIDTH-1:0]  fwd_data,
  output logic [63:0]               instret
);

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_LOAD = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  logic                      r_wb_valid;
  logic                      r_wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
  logic [OPERAND_WIDTH-1:0]  r_wb_data;
  logic                      r_wb_written;

  logic [OPERAND_WIDTH-1:0]  w_wb_data;
  logic                      w_live_dest;
  logic                      w_rf_we;

  // NOTE: assign a default before the case so every path drives the mux and no latch is inferred.
  always_comb begin
    w_wb_data = mem_alu_result;
    case (wb_sel_e'(mem_wb_sel))
      SEL_LOAD: w_wb_data = OPERAND_WIDTH'(mem_data);
      SEL_PC4:  w_wb_data = mem_pc_plus4;
      default:  w_wb_data = mem_alu_result;
    endcase
  end

  assign w_live_dest = r_wb_valid & r_wb_reg_write & (r_wb_rd != '0);
  assign w_rf_we     = w_live_dest & ~r_wb_written;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_wb_written   <= 1'b0;
    end else if (flush) begin
      r_wb_valid <= 1'b0;
    end else if (stall) begin
      // A held entry remembers it already wrote so the regfile sees it exactly once.
      if (w_rf_we) r_wb_written <= 1'b1;
    end else begin
      r_wb_valid     <= mem_valid;
      r_wb_reg_write <= mem_reg_write;
      r_wb_rd        <= mem_rd;
      r_wb_data      <= w_wb_data;
      r_wb_written   <= 1'b0;
    end
  end

  assign rf_we     = w_rf_we;
  assign rf_waddr  = r_wb_rd;
  assign rf_wdata  = r_wb_data;
  assign fwd_valid = w_live_dest;
  assign fwd_rd    = r_wb_rd;
  assign fwd_data  = r_wb_data;

`ifdef RETIRE_COUNT_EN
  logic        r_wb_counted;
  logic [63:0] r_instret;
  logic        w_retire;

  // An entry retires in its first valid cycle, whether or not it writes rd.
  assign w_retire = r_wb_valid & ~r_wb_counted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_counted <= 1'b0;
      r_instret    <= '0;
    end else begin
      if (w_retire) r_instret <= r_instret + 64'd1;
      if (!flush) begin
        if (stall) r_wb_counted <= 1'b1;
        else       r_wb_counted <= 1'b0;
      end
    end
  end

  assign instret = r_instret;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver pushes model predictions, a monitor pops and compares.
module tb_mem_wb_stage;
  localparam int OW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid;
  logic [OW-1:0] mem_alu_result;
  logic [31:0]   mem_data;
  logic [OW-1:0] mem_pc_plus4;
  logic [RW-1:0] mem_rd;
  logic          mem_reg_write;
  logic [1:0]    mem_wb_sel;
  logic          stall;
  logic          flush;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [OW-1:0] rf_wdata;
  logic          fwd_valid;
  logic [RW-1:0] fwd_rd;
  logic [OW-1:0] fwd_data;
  logic [63:0]   instret;

  mem_wb_stage #(.OPERAND_WIDTH(OW), .REG_ADDR_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_data(mem_data), .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel), .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rf_we;
    logic          fwd_valid;
    logic [RW-1:0] rd;
    logic [OW-1:0] data;
    logic          cmp_data;
    logic [63:0]   instret;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: the WB entry plus how many cycles it has been held by stall.
  logic          m_valid = 1'b0;
  logic          m_rw    = 1'b0;
  logic [RW-1:0] m_rd    = '0;
  logic [OW-1:0] m_data  = '0;
  int            m_age   = 0;
  logic [63:0]   m_count = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic rw, input logic [RW-1:0] rd,
                       input logic [1:0] sel, input logic [OW-1:0] alu, input logic [31:0] ld,
                       input logic [OW-1:0] pc4, input logic st, input logic fl, input logic wrap);
    exp_t          e;
    logic [OW-1:0] sel_val;
    @(negedge clk);
`ifdef RETIRE_COUNT_EN
    if (wrap) begin
      force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.r_instret;
      m_count = 64'hFFFF_FFFF_FFFF_FFFF;
    end
`else
    if (wrap) m_count = '0;
`endif
    rst = r; mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_alu_result = alu; mem_data = ld; mem_pc_plus4 = pc4; stall = st; flush = fl;

    case (sel)
      2'b01:   sel_val = ld;
      2'b10:   sel_val = pc4;
      default: sel_val = alu;
    endcase

    if (!r) begin
      m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_data = '0; m_age = 0; m_count = '0;
    end else begin
      if (m_valid && m_age == 0) m_count = m_count + 64'd1;
      if (fl) m_valid = 1'b0;
      else if (st) m_age++;
      else begin
        m_valid = v; m_rw = rw; m_rd = rd; m_data = sel_val; m_age = 0;
      end
    end

    e.fwd_valid = m_valid && m_rw && (m_rd != '0);
    e.rf_we     = e.fwd_valid && (m_age == 0);
    e.rd        = m_rd;
    e.data      = m_data;
    e.cmp_data  = m_valid || !r;
`ifdef RETIRE_COUNT_EN
    e.instret = m_count;
`else
    e.instret = 64'd0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic drive_rand(input logic r, input logic st, input logic fl);
    drive(r, 1'($urandom), 1'($urandom), RW'($urandom), 2'($urandom), $urandom, $urandom,
          $urandom, st, fl, 1'b0);
  endtask

  // Monitor: one expectation per cycle, compared just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("rf_we", 64'(rf_we), 64'(e.rf_we));
        check("fwd_valid", 64'(fwd_valid), 64'(e.fwd_valid));
        check("instret", instret, e.instret);
        if (e.cmp_data) begin
          check("rf_waddr", 64'(rf_waddr), 64'(e.rd));
          check("rf_wdata", 64'(rf_wdata), 64'(e.data));
          check("fwd_rd", 64'(fwd_rd), 64'(e.rd));
          check("fwd_data", 64'(fwd_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; mem_valid = 1'b0; mem_alu_result = '0; mem_data = '0; mem_pc_plus4 = '0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_wb_sel = 2'b00; stall = 1'b0; flush = 1'b0;

    // Reset held with random inputs.
    repeat (3) drive_rand(1'b0, 1'($urandom), 1'($urandom));

    // First capture and write-back mux selects.
    drive(1, 1, 1, 5, 2'b00, 32'h1234, $urandom, $urandom, 0, 0, 0);
    drive(1, 1, 1, 6, 2'b01, $urandom, 32'hFFFF_FF80, $urandom, 0, 0, 0);
    drive(1, 1, 1, 1, 2'b10, $urandom, $urandom, 32'h104, 0, 0, 0);
    drive(1, 1, 1, 2, 2'b11, 32'hCAFE, $urandom, $urandom, 0, 0, 0);

    // x0 destination retires but never writes or forwards.
    drive(1, 1, 1, 0, 2'b00, 32'h77, $urandom, $urandom, 0, 0, 0);

    // Stalled entry writes once, forwards throughout.
    drive(1, 1, 1, 7, 2'b00, 32'hA5, $urandom, $urandom, 0, 0, 0);
    repeat (3) drive_rand(1'b1, 1'b1, 1'b0);

    // flush+stall on a live incoming instruction, then normal traffic to the same rd.
    drive(1, 1, 1, 9, 2'b00, 32'hBEEF, $urandom, $urandom, 1, 1, 0);
    drive(1, 1, 1, 9, 2'b00, 32'h55, $urandom, $urandom, 0, 0, 0);
    drive(1, 1, 1, 9, 2'b00, 32'h66, $urandom, $urandom, 0, 0, 0);
    drive(1, 1, 1, 9, 2'b01, $urandom, 32'h77, $urandom, 0, 0, 0);

    // Bubble, then a store-like instruction that retires without writing.
    drive(1, 0, 1, 4, 2'b00, $urandom, $urandom, $urandom, 0, 0, 0);
    drive(1, 1, 0, 3, 2'b00, $urandom, $urandom, $urandom, 0, 0, 0);

    // Counter wrap.
    drive(1, 1, 1, 4, 2'b00, 32'h1, $urandom, $urandom, 0, 0, 1);
    drive(1, 1, 1, 4, 2'b00, 32'h2, $urandom, $urandom, 0, 0, 0);

    // Reset during a stall drops the held instruction.
    drive(1, 1, 1, 8, 2'b00, 32'h88, $urandom, $urandom, 0, 0, 0);
    drive_rand(1'b1, 1'b1, 1'b0);
    drive_rand(1'b0, 1'b1, 1'b0);
    drive(1, 1, 1, 10, 2'b00, 32'h1010, $urandom, $urandom, 0, 0, 0);

    // Randomized traffic with a small rd range to exercise x0 and repeated destinations.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(99) != 0), ($urandom_range(3) != 0), 1'($urandom),
            RW'($urandom_range(3)), 2'($urandom), $urandom, $urandom, $urandom,
            ($urandom_range(3) == 0), ($urandom_range(7) == 0), 1'b0);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
